// File: rtl/mmio_hub_if.sv
// mmio_hub_if: CPU data-memory-side bus for the MMIO hub.
//   Address   - CPU byte address
//   WriteData - store data
//   WrEn      - store strobe, one cycle per store
//   RdEn      - load strobe; only qualifies read side effects
//   DataIo    - combinational read data returned by the hub
// The CPU side uses the master modport and the hub uses the slave modport.
interface mmio_hub_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        WrEn;
  logic        RdEn;
  logic [31:0] DataIo;

  modport master (output Address, WriteData, WrEn, RdEn, input DataIo);
  modport slave  (input Address, WriteData, WrEn, RdEn, output DataIo);
endinterface

// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O hub beside data memory.
// It provides switch banks, LED banks, debounced buttons with sticky press
// latches, a seven-segment register, a free-running timer with a compare
// interrupt, and a VGA char/colour text buffer. The text buffer is zeroed by
// a hardware sweep after every reset.
// Ports:
//   clk        - sole clock
//   reset      - synchronous, active-low
//   bus        - CPU bus (Address/WriteData/WrEn/RdEn in, DataIo out)
//   Switch     - switch banks, bank i at [i*SW_WIDTH +: SW_WIDTH]
//   Button     - raw asynchronous push buttons
//   LedOut     - LED banks, same packing as Switch
//   Seg1Out    - seven-segment value
//   TimerIrq   - level interrupt, mirrors the match status bit
//   VgaAddress - VGA scan cell index
//   CharOut    - registered char buffer contents at VgaAddress
//   ColorOut   - registered colour buffer contents at VgaAddress
module mmio_hub #(
  parameter int NUM_SW          = 3,
  parameter int SW_WIDTH        = 8,
  parameter int NUM_LED         = 2,
  parameter int LED_WIDTH       = 8,
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int VGA_CELLS       = 3072,
  localparam int VGA_AW = (VGA_CELLS > 1) ? $clog2(VGA_CELLS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  mmio_hub_if.slave                      bus,
  input  logic [NUM_SW*SW_WIDTH-1:0]     Switch,
  input  logic [NUM_BTN-1:0]             Button,
  output logic [NUM_LED*LED_WIDTH-1:0]   LedOut,
  output logic [31:0]                    Seg1Out,
  output logic                           TimerIrq,
  input  logic [VGA_AW-1:0]              VgaAddress,
  output logic [7:0]                     CharOut,
  output logic [7:0]                     ColorOut
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [VGA_AW-1:0] PTR_LAST = VGA_AW'(VGA_CELLS - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;

  // ---------------- address decode ----------------
  logic        io_sel, char_sel, color_sel, vga_in_range;
  logic [7:0]  io_off;
  logic [11:0] vga_idx;

  assign io_sel       = (bus.Address[31:8] == 24'hFF_FFFF);
  assign io_off       = bus.Address[7:0];
  assign char_sel     = (bus.Address[31:12] == 20'hFFFF_E);
  assign color_sel    = (bus.Address[31:12] == 20'hFFFF_D);
  assign vga_idx      = bus.Address[11:0];
  assign vga_in_range = ({1'b0, vga_idx} < 13'(VGA_CELLS));

  logic wr_io, wr_seg, wr_timer, wr_cmp, wr_status, wr_press, rd_press;
  assign wr_io     = bus.WrEn & io_sel;
  assign wr_seg    = wr_io & (io_off == 8'h88);
  assign wr_timer  = wr_io & (io_off == 8'h8C);
  assign wr_cmp    = wr_io & (io_off == 8'h90);
  assign wr_status = wr_io & (io_off == 8'h94);
  assign wr_press  = wr_io & (io_off == 8'h84);
  assign rd_press  = bus.RdEn & io_sel & (io_off == 8'h84);

  // ---------------- state ----------------
  logic [LED_WIDTH-1:0] led_q [NUM_LED];
  logic [LED_WIDTH-1:0] led_d [NUM_LED];
  logic [31:0]          seg_q, seg_d, timer_q, timer_d, cmp_q, cmp_d;
  logic                 match_q, match_d;
  logic [NUM_BTN-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BTN-1:0]   deb_q, deb_d, press_q, press_d, press_clr;
  logic [CNT_W-1:0]     cnt_q [NUM_BTN];
  logic [CNT_W-1:0]     cnt_d [NUM_BTN];
  clr_state_e           state_q, state_d;
  logic [VGA_AW-1:0]    ptr_q, ptr_d;
  logic                 clear_busy;
  logic [7:0]           char_rd_q, color_rd_q;

  logic [7:0] char_mem  [VGA_CELLS];
  logic [7:0] color_mem [VGA_CELLS];

  // ---------------- register / button next-state ----------------
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      led_d[i] = led_q[i];
      if (wr_io && io_off == 8'(64 + 4 * i)) led_d[i] = bus.WriteData[LED_WIDTH-1:0];
    end
    seg_d   = wr_seg ? bus.WriteData : seg_q;
    cmp_d   = wr_cmp ? bus.WriteData : cmp_q;
    timer_d = wr_timer ? bus.WriteData : timer_q + 32'd1;
    // A match in the same cycle as a clearing write keeps the bit set.
    match_d = (match_q & ~(wr_status & bus.WriteData[0])) | (timer_q == cmp_q);

    sync1_d = Button;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int b = 0; b < NUM_BTN; b++) begin
      cnt_d[b] = cnt_q[b];
      if (sync2_q[b] == deb_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        deb_d[b] = ~deb_q[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
    // A read clears exactly the bits it returned; a rising level arriving
    // in the same cycle is OR-ed in afterwards so it is never lost.
    press_clr = (rd_press ? press_q : '0) | (wr_press ? bus.WriteData[NUM_BTN-1:0] : '0);
    press_d   = (press_q & ~press_clr) | (deb_d & ~deb_q);
  end

  // ---------------- clear FSM and buffer write port ----------------
  logic              mem_we_char, mem_we_color;
  logic [VGA_AW-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_busy   = 1'b0;
    mem_we_char  = 1'b0;
    mem_we_color = 1'b0;
    mem_waddr    = vga_idx[VGA_AW-1:0];
    mem_wdata    = bus.WriteData[7:0];
    case (state_q)
      ST_CLEAR: begin
        // The sweep owns the write port; CPU buffer stores are dropped.
        clear_busy   = 1'b1;
        mem_we_char  = 1'b1;
        mem_we_color = 1'b1;
        mem_waddr    = ptr_q;
        mem_wdata    = 8'h00;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + VGA_AW'(1);
        end
      end
      ST_IDLE: begin
        mem_we_char  = bus.WrEn & char_sel & vga_in_range;
        mem_we_color = bus.WrEn & color_sel & vga_in_range;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- sequential state ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LED; i++) led_q[i] <= '0;
      for (int b = 0; b < NUM_BTN; b++) cnt_q[b] <= '0;
      seg_q      <= '0;
      timer_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      press_q    <= '0;
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      char_rd_q  <= 8'h00;
      color_rd_q <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_LED; i++) led_q[i] <= led_d[i];
      for (int b = 0; b < NUM_BTN; b++) cnt_q[b] <= cnt_d[b];
      seg_q      <= seg_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      press_q    <= press_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      // Read-first: a write to the scanned cell shows up one cycle later.
      char_rd_q  <= char_mem[VgaAddress];
      color_rd_q <= color_mem[VgaAddress];
    end
  end

  // Buffer arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_char)  char_mem[mem_waddr]  <= mem_wdata;
    if (mem_we_color) color_mem[mem_waddr] <= mem_wdata;
  end

  // ---------------- read mux ----------------
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      for (int i = 0; i < NUM_SW; i++)
        if (io_off == 8'(4 * i)) rdata[SW_WIDTH-1:0] = Switch[i*SW_WIDTH +: SW_WIDTH];
      for (int i = 0; i < NUM_LED; i++)
        if (io_off == 8'(64 + 4 * i)) rdata[LED_WIDTH-1:0] = led_q[i];
      case (io_off)
        8'h80:   rdata[NUM_BTN-1:0] = deb_q;
        8'h84:   rdata[NUM_BTN-1:0] = press_q;
        8'h88:   rdata = seg_q;
        8'h8C:   rdata = timer_q;
        8'h90:   rdata = cmp_q;
        8'h94:   rdata[1:0] = {clear_busy, match_q};
        default: ;
      endcase
    end
  end
  assign bus.DataIo = rdata;

  // ---------------- outputs ----------------
  for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
    assign LedOut[gi*LED_WIDTH +: LED_WIDTH] = led_q[gi];
  end

  assign Seg1Out  = seg_q;
  assign TimerIrq = match_q;
  assign CharOut  = char_rd_q;
  assign ColorOut = color_rd_q;

endmodule

// File: tb/tb_mmio_hub.sv
module tb_mmio_hub;
  localparam int NSW = 3, SWW = 8, NLED = 2, LEDW = 8, NBTN = 5, DEB = 16, CELLS = 3072;
  localparam logic [31:0] A_LED0 = 32'hFFFF_FF40, A_LED1 = 32'hFFFF_FF44;
  localparam logic [31:0] A_BTN = 32'hFFFF_FF80, A_PRESS = 32'hFFFF_FF84, A_SEG = 32'hFFFF_FF88;
  localparam logic [31:0] A_TMR = 32'hFFFF_FF8C, A_CMP = 32'hFFFF_FF90, A_STAT = 32'hFFFF_FF94;
  localparam logic [31:0] A_CHAR = 32'hFFFF_E000, A_COL = 32'hFFFF_D000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mmio_hub_if bus();
  logic [NSW*SWW-1:0]   sw = '0;
  logic [NBTN-1:0]      btn = '0;
  logic [NLED*LEDW-1:0] led;
  logic [31:0]          seg;
  logic                 irq;
  logic [11:0]          vaddr = '0;
  logic [7:0]           ch, co;

  mmio_hub #(.NUM_SW(NSW), .SW_WIDTH(SWW), .NUM_LED(NLED), .LED_WIDTH(LEDW),
             .NUM_BTN(NBTN), .DEBOUNCE_CYCLES(DEB), .VGA_CELLS(CELLS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .Switch(sw), .Button(btn),
    .LedOut(led), .Seg1Out(seg), .TimerIrq(irq), .VgaAddress(vaddr),
    .CharOut(ch), .ColorOut(co));

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]  char_m [CELLS];
  logic [7:0]  col_m  [CELLS];
  logic [7:0]  led_m  [NLED];
  logic [31:0] seg_m, cmp_m, tbase;
  int unsigned tcyc;

  // Timer value = last loaded value plus clock edges since the load.
  function automatic logic [31:0] timer_m();
    return tbase + 32'(cyc - tcyc);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a; bus.WriteData = d; bus.WrEn = 1'b1;
    step();
    bus.WrEn = 1'b0;
    $display("[TB] write addr=%08h data=%08h", a, d);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    bus.Address = a;
    #1;
    v = bus.DataIo;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) begin char_m[i] = 8'h00; col_m[i] = 8'h00; end
    for (int i = 0; i < NLED; i++) led_m[i] = 8'h00;
    seg_m = 0; cmp_m = 0; tbase = 0; tcyc = cyc;
  endtask

  // Counts cycles with clear_busy = 1, starting at the reset-release point.
  task automatic count_busy(input bit extra, output int n);
    logic [31:0] v;
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      peek(A_STAT, v);
      if (!v[1]) break;
      n++;
      if (extra && k == 1) begin
        peek(A_LED0, v); tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL rst_led0 got=%0h exp=0", v); end
        peek(A_LED1, v); tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL rst_led1 got=%0h exp=0", v); end
        peek(A_SEG, v); tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL rst_seg got=%0h exp=0", v); end
        peek(A_TMR, v); tests++;
        if (v !== timer_m() || v !== 32'd1) begin fails++; $display("FAIL rst_timer got=%0h exp=1", v); end
      end
      if (extra && k == 100) begin
        bus.Address = A_CHAR + 32'd50; bus.WriteData = 32'h77; bus.WrEn = 1'b1;
      end
      step();
      bus.WrEn = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    step(2);
    tests++;
    if (led !== '0 || seg !== 32'h0 || irq !== 1'b0 || ch !== 8'h0 || co !== 8'h0) begin
      fails++; $display("FAIL reset_outputs got=%0h/%0h/%0b/%0h/%0h exp=0", led, seg, irq, ch, co);
    end
    reset = 1'b1;
    model_reset();
    count_busy(1'b1, n);
    tests++;
    if (n != CELLS) begin fails++; $display("FAIL sweep_len got=%0d exp=%0d", n, CELLS); end
    vaddr = 12'd50;
    step();
    tests++;
    if (ch !== 8'h00) begin fails++; $display("FAIL drop_in_clear got=%0h exp=0", ch); end
  endtask

  task automatic test_switch();
    logic [31:0] v;
    for (int r = 0; r < 5; r++) begin
      sw = (r == 0) ? 24'h5AA53C : 24'($urandom);
      for (int i = 0; i < NSW; i++) begin
        peek(32'hFFFF_FF00 + 32'(4 * i), v);
        tests++;
        if (v !== {24'h0, sw[i*SWW +: SWW]}) begin
          fails++; $display("FAIL switch%0d got=%0h exp=%0h", i, v, sw[i*SWW +: SWW]);
        end
      end
      step();
    end
    tests++;
    if (sw === 24'h5AA53C) begin fails++; $display("FAIL switch_random got=%0h exp=other", sw); end
    // Unmapped holes, wrong page, and write-only buffer reads all return 0.
    peek(32'hFFFF_FF0C, v); tests++;
    if (v !== 0) begin fails++; $display("FAIL unmapped_0c got=%0h exp=0", v); end
    peek(32'hFFFF_FF98, v); tests++;
    if (v !== 0) begin fails++; $display("FAIL unmapped_98 got=%0h exp=0", v); end
    peek(32'h0000_0004, v); tests++;
    if (v !== 0) begin fails++; $display("FAIL wrong_page got=%0h exp=0", v); end
    step();
  endtask

  task automatic test_led_seg();
    logic [31:0] v, d;
    int b;
    wr(A_LED1, 32'h1FF); led_m[1] = 8'hFF;
    tests++;
    if (led[15:8] !== 8'hFF) begin fails++; $display("FAIL led1_1ff got=%0h exp=ff", led[15:8]); end
    for (int r = 0; r < 6; r++) begin
      b = $urandom_range(0, NLED - 1);
      d = $urandom;
      wr(A_LED0 + 32'(4 * b), d); led_m[b] = d[7:0];
      tests++;
      if (led !== {led_m[1], led_m[0]}) begin
        fails++; $display("FAIL led_out got=%0h exp=%0h", led, {led_m[1], led_m[0]});
      end
      peek(A_LED0 + 32'(4 * b), v); tests++;
      if (v !== {24'h0, led_m[b]}) begin fails++; $display("FAIL led_read got=%0h exp=%0h", v, led_m[b]); end
    end
    d = $urandom;
    wr(A_SEG, d); seg_m = d;
    peek(A_SEG, v); tests++;
    if (seg !== seg_m || v !== seg_m) begin fails++; $display("FAIL seg got=%0h/%0h exp=%0h", seg, v, seg_m); end
  endtask

  task automatic test_button();
    logic [31:0] v;
    logic [4:0] m;
    int n;
    // Glitch shorter than the debounce window.
    btn[0] = 1'b1; step(5); btn[0] = 1'b0; step(30);
    peek(A_BTN, v); tests++;
    if (v !== 0) begin fails++; $display("FAIL glitch_level got=%0h exp=0", v); end
    peek(A_PRESS, v); tests++;
    if (v !== 0) begin fails++; $display("FAIL glitch_latch got=%0h exp=0", v); end
    // Held press: level rises after 2 sync + DEB edges.
    btn[0] = 1'b1;
    n = 0;
    do begin step(); n++; peek(A_BTN, v); end while (!v[0] && n < 100);
    tests++;
    if (n != DEB + 2) begin fails++; $display("FAIL press_latency got=%0d exp=%0d", n, DEB + 2); end
    step(2);
    peek(A_PRESS, v); tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL latch_set got=%0h exp=1", v); end
    bus.RdEn = 1'b1; peek(A_PRESS, v); step(); bus.RdEn = 1'b0;
    $display("[TB] read  addr=%08h data=%08h", A_PRESS, v);
    tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL rd_clear_ret got=%0h exp=1", v); end
    peek(A_PRESS, v); tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL rd_clear_after got=%0h exp=0", v); end
    // Release does not latch.
    btn[0] = 1'b0; step(25);
    peek(A_PRESS, v); tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL release_latch got=%0h exp=0", v); end
    // A press edge landing on the clearing read survives.
    btn[1] = 1'b1; step(20);
    btn[2] = 1'b1; step(DEB + 1);
    bus.RdEn = 1'b1; peek(A_PRESS, v); step(); bus.RdEn = 1'b0;
    $display("[TB] read  addr=%08h data=%08h", A_PRESS, v);
    tests++;
    if (v !== 32'h2) begin fails++; $display("FAIL race_ret got=%0h exp=2", v); end
    peek(A_PRESS, v); tests++;
    if (v !== 32'h4) begin fails++; $display("FAIL race_keep got=%0h exp=4", v); end
    peek(A_BTN, v); tests++;
    if (v !== 32'h6) begin fails++; $display("FAIL race_level got=%0h exp=6", v); end
    wr(A_PRESS, 32'h4);
    peek(A_PRESS, v); tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL w1c_press got=%0h exp=0", v); end
    // Random masks of held buttons.
    for (int r = 0; r < 2; r++) begin
      btn = '0; step(25); wr(A_PRESS, 32'h1F);
      m = 5'($urandom_range(1, 31));
      btn = m; step(25);
      peek(A_BTN, v); tests++;
      if (v !== {27'h0, m}) begin fails++; $display("FAIL rand_level got=%0h exp=%0h", v, m); end
      peek(A_PRESS, v); tests++;
      if (v !== {27'h0, m}) begin fails++; $display("FAIL rand_latch got=%0h exp=%0h", v, m); end
    end
    btn = '0; step(25);
  endtask

  task automatic test_timer();
    logic [31:0] v, c;
    bit exp;
    wr(A_CMP, 32'h1); cmp_m = 32'h1;
    peek(A_CMP, v); tests++;
    if (v !== cmp_m) begin fails++; $display("FAIL cmp_read got=%0h exp=%0h", v, cmp_m); end
    wr(A_STAT, 32'h1); tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear0 got=%0b exp=0", irq); end
    wr(A_TMR, 32'hFFFF_FFFE); tbase = 32'hFFFF_FFFE; tcyc = cyc;
    exp = 1'b0;
    for (int j = 0; j < 7; j++) begin
      peek(A_TMR, v); tests++;
      if (v !== timer_m()) begin fails++; $display("FAIL timer_wrap got=%0h exp=%0h", v, timer_m()); end
      tests++;
      if (irq !== exp) begin fails++; $display("FAIL irq_rise j=%0d got=%0b exp=%0b", j, irq, exp); end
      if (timer_m() == cmp_m) exp = 1'b1;
      step();
    end
    wr(A_STAT, 32'h1); tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_w1c got=%0b exp=0", irq); end
    // Clearing write on the very edge that sees a match: set wins.
    wr(A_TMR, 32'hFFFF_FFFE); tbase = 32'hFFFF_FFFE; tcyc = cyc;
    for (int j = 0; j < 5 && timer_m() != cmp_m; j++) step();
    wr(A_STAT, 32'h1); tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL set_wins got=%0b exp=1", irq); end
    wr(A_STAT, 32'h1);
    peek(A_STAT, v); tests++;
    if (v[0] !== 1'b0 || irq !== 1'b0) begin fails++; $display("FAIL stat_clear got=%0h exp=0", v); end
    // Random compare points in the near future.
    for (int r = 0; r < 3; r++) begin
      c = timer_m() + 32'($urandom_range(6, 40));
      wr(A_CMP, c); cmp_m = c;
      wr(A_STAT, 32'h1);
      exp = 1'b0;
      for (int j = 0; j < 50; j++) begin
        tests++;
        if (irq !== exp) begin fails++; $display("FAIL irq_rand r=%0d got=%0b exp=%0b", r, irq, exp); end
        if (timer_m() == cmp_m) exp = 1'b1;
        step();
      end
    end
  endtask

  task automatic test_vga();
    logic [31:0] v;
    logic [7:0] d;
    int idx;
    wr(A_CHAR + 32'd5, 32'h41); char_m[5] = 8'h41;
    wr(A_COL + 32'd5, 32'h0C);  col_m[5] = 8'h0C;
    vaddr = 12'd5; step(); tests++;
    if (ch !== 8'h41 || co !== 8'h0C) begin fails++; $display("FAIL vga_cell5 got=%0h/%0h exp=41/0c", ch, co); end
    peek(A_CHAR + 32'd5, v); tests++;
    if (v !== 0) begin fails++; $display("FAIL vga_readback got=%0h exp=0", v); end
    // Write under the scan: old data for one cycle, then new.
    vaddr = 12'd9; step();
    wr(A_CHAR + 32'd9, 32'h99); tests++;
    if (ch !== char_m[9]) begin fails++; $display("FAIL vga_old got=%0h exp=%0h", ch, char_m[9]); end
    char_m[9] = 8'h99;
    step(); tests++;
    if (ch !== 8'h99) begin fails++; $display("FAIL vga_new got=%0h exp=99", ch); end
    // Out-of-range index is ignored.
    wr(32'hFFFF_EC00, 32'hEE); wr(32'hFFFF_DC00, 32'hEE);
    for (int r = 0; r < 20; r++) begin
      idx = $urandom_range(0, CELLS - 1); d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin wr(A_CHAR + 32'(idx), {24'h0, d}); char_m[idx] = d; end
      else begin wr(A_COL + 32'(idx), {24'h0, d}); col_m[idx] = d; end
    end
    for (int r = 0; r < 24; r++) begin
      idx = (r < 4) ? ((r == 0) ? 0 : (r == 1) ? CELLS - 1 : (r == 2) ? 1024 : 2048) : $urandom_range(0, CELLS - 1);
      vaddr = 12'(idx); step(); tests++;
      if (ch !== char_m[idx] || co !== col_m[idx]) begin
        fails++; $display("FAIL vga_scan idx=%0d got=%0h/%0h exp=%0h/%0h", idx, ch, co, char_m[idx], col_m[idx]);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    logic [31:0] v;
    int n;
    reset = 1'b0; step(); reset = 1'b1; model_reset();
    n = 0;
    for (int k = 0; k < 1000; k++) begin peek(A_STAT, v); if (v[1]) n++; step(); end
    tests++;
    if (n != 1000) begin fails++; $display("FAIL first_sweep got=%0d exp=1000", n); end
    reset = 1'b0; step(); reset = 1'b1; model_reset();
    count_busy(1'b0, n);
    tests++;
    if (n != CELLS) begin fails++; $display("FAIL restart_len got=%0d exp=%0d", n, CELLS); end
    vaddr = 12'd9; step(); tests++;
    if (ch !== 8'h00 || led !== '0) begin fails++; $display("FAIL after_restart got=%0h/%0h exp=0", ch, led); end
  endtask

  initial begin
    bus.Address = '0; bus.WriteData = '0; bus.WrEn = 1'b0; bus.RdEn = 1'b0;
    step();
    test_reset();
    test_switch();
    test_led_seg();
    test_button();
    test_timer();
    test_vga();
    test_reset_midsweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
